// File: rtl/matmul_tile_sequencer.sv
// K-dimension tile sequencer for matrix_multiplication: drives start/clear_done per tile,
// steps A/B base addresses, chains accumulator flags and masks the ragged last tile.
module matmul_tile_sequencer #(
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned SWIDTH = 8,
    parameter int unsigned TILE   = 8,
    parameter int unsigned NTW    = 4,
    parameter int unsigned TOW    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NTW-1:0]          num_k_tiles,
    input  logic [$clog2(TILE):0]   k_last_valid,
    input  logic [AWIDTH-1:0]       base_a,
    input  logic [AWIDTH-1:0]       base_b,
    input  logic [AWIDTH-1:0]       base_c,
    input  logic [AWIDTH-1:0]       step_a,
    input  logic [AWIDTH-1:0]       step_b,
    input  logic [SWIDTH-1:0]       stride_a,
    input  logic [SWIDTH-1:0]       stride_b,
    input  logic [SWIDTH-1:0]       stride_c,
    input  logic [TILE-1:0]         mask_a_rows,
    input  logic [TILE-1:0]         mask_b_cols,
    input  logic [TOW-1:0]          timeout,
    input  logic                    mm_done,
    output logic                    mm_start,
    output logic                    mm_clear_done,
    output logic [AWIDTH-1:0]       mm_addr_a,
    output logic [AWIDTH-1:0]       mm_addr_b,
    output logic [AWIDTH-1:0]       mm_addr_c,
    output logic [SWIDTH-1:0]       mm_stride_a,
    output logic [SWIDTH-1:0]       mm_stride_b,
    output logic [SWIDTH-1:0]       mm_stride_c,
    output logic                    mm_save_accum,
    output logic                    mm_add_accum,
    output logic [TILE-1:0]         mm_mask_a_rows,
    output logic [TILE-1:0]         mm_mask_k,
    output logic [TILE-1:0]         mm_mask_b_cols,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NTW-1:0]          tile_idx
);

    localparam int unsigned KW = $clog2(TILE) + 1;

    typedef enum logic [2:0] {StIdle, StRun, StClear, StFin, StErr} state_e;

    state_e state_q, state_d;

    // Latched configuration
    logic [NTW-1:0]    cfg_num_k_q, cfg_num_k_d;
    logic [KW-1:0]     cfg_klv_q, cfg_klv_d;
    logic [AWIDTH-1:0] cfg_step_a_q, cfg_step_a_d;
    logic [AWIDTH-1:0] cfg_step_b_q, cfg_step_b_d;
    logic [TOW-1:0]    cfg_timeout_q, cfg_timeout_d;
    logic [TOW-1:0]    wd_cnt_q, wd_cnt_d;

    // Output registers
    logic              mm_start_q, mm_start_d;
    logic              mm_clear_done_q, mm_clear_done_d;
    logic [AWIDTH-1:0] addr_a_q, addr_a_d;
    logic [AWIDTH-1:0] addr_b_q, addr_b_d;
    logic [AWIDTH-1:0] addr_c_q, addr_c_d;
    logic [SWIDTH-1:0] stride_a_q, stride_a_d;
    logic [SWIDTH-1:0] stride_b_q, stride_b_d;
    logic [SWIDTH-1:0] stride_c_q, stride_c_d;
    logic              save_q, save_d;
    logic              add_q, add_d;
    logic [TILE-1:0]   mask_a_q, mask_a_d;
    logic [TILE-1:0]   mask_k_q, mask_k_d;
    logic [TILE-1:0]   mask_b_q, mask_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [NTW-1:0]    tile_idx_q, tile_idx_d;

    logic              accept;
    logic              start_run;
    logic              advance;
    logic              last_tile;
    logic              wd_expire;
    logic              last_next;
    logic [NTW-1:0]    n_eff;
    logic [KW-1:0]     klv_eff;

    assign accept    = (state_q == StIdle) && start && !abort;
    assign start_run = accept && (num_k_tiles != '0);
    assign advance   = (state_q == StClear) && (state_d == StRun);
    assign last_tile = (tile_idx_q == cfg_num_k_q - NTW'(1));
    assign wd_expire = (cfg_timeout_q != '0) && (wd_cnt_q == cfg_timeout_q - TOW'(1));

    function automatic logic [TILE-1:0] k_mask(input logic last, input logic [KW-1:0] klv);
        logic [TILE-1:0] m;
        for (int i = 0; i < TILE; i++) begin
            m[i] = !last || (klv == '0) || (KW'(i) < klv);
        end
        return m;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_k_tiles == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (mm_done) begin
                    state_d = StClear;
                end else if (wd_expire) begin
                    state_d = StErr;
                end
            end
            StClear: begin
                if (!mm_done) begin
                    state_d = last_tile ? StFin : StRun;
                end
            end
            StFin: state_d = StIdle;
            StErr: begin
                if (!mm_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        cfg_num_k_d   = accept ? num_k_tiles : cfg_num_k_q;
        cfg_klv_d     = accept ? k_last_valid : cfg_klv_q;
        cfg_step_a_d  = accept ? step_a : cfg_step_a_q;
        cfg_step_b_d  = accept ? step_b : cfg_step_b_q;
        cfg_timeout_d = accept ? timeout : cfg_timeout_q;

        wd_cnt_d = (state_q == StRun) ? wd_cnt_q + TOW'(1) : '0;

        mm_start_d      = (state_d == StRun);
        mm_clear_done_d = (state_d == StClear) || (state_d == StErr);
        busy_d          = (state_d != StIdle);
        done_d          = (state_d == StFin);
        err_d           = (state_d == StErr) || (err_q && !accept);

        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        addr_c_d   = addr_c_q;
        stride_a_d = stride_a_q;
        stride_b_d = stride_b_q;
        stride_c_d = stride_c_q;
        mask_a_d   = mask_a_q;
        mask_b_d   = mask_b_q;
        mask_k_d   = mask_k_q;
        save_d     = save_q;
        add_d      = add_q;
        tile_idx_d = tile_idx_q;
        last_next  = 1'b0;
        n_eff      = start_run ? num_k_tiles : cfg_num_k_q;
        klv_eff    = start_run ? k_last_valid : cfg_klv_q;

        if (accept) begin
            tile_idx_d = '0;
        end
        if (start_run) begin
            addr_a_d   = base_a;
            addr_b_d   = base_b;
            addr_c_d   = base_c;
            stride_a_d = stride_a;
            stride_b_d = stride_b;
            stride_c_d = stride_c;
            mask_a_d   = mask_a_rows;
            mask_b_d   = mask_b_cols;
        end else if (advance) begin
            tile_idx_d = tile_idx_q + NTW'(1);
            addr_a_d   = addr_a_q + cfg_step_a_q;
            addr_b_d   = addr_b_q + cfg_step_b_q;
        end
        // Flags and K mask only move when a tile is launched, so they hold across RUN/CLEAR.
        if (start_run || advance) begin
            last_next = (tile_idx_d == n_eff - NTW'(1));
            save_d    = !last_next;
            add_d     = (tile_idx_d != '0);
            mask_k_d  = k_mask(last_next, klv_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_num_k_q     <= '0;
            cfg_klv_q       <= '0;
            cfg_step_a_q    <= '0;
            cfg_step_b_q    <= '0;
            cfg_timeout_q   <= '0;
            wd_cnt_q        <= '0;
            mm_start_q      <= 1'b0;
            mm_clear_done_q <= 1'b0;
            addr_a_q        <= '0;
            addr_b_q        <= '0;
            addr_c_q        <= '0;
            stride_a_q      <= '0;
            stride_b_q      <= '0;
            stride_c_q      <= '0;
            save_q          <= 1'b0;
            add_q           <= 1'b0;
            mask_a_q        <= '0;
            mask_k_q        <= '0;
            mask_b_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            tile_idx_q      <= '0;
        end else begin
            cfg_num_k_q     <= cfg_num_k_d;
            cfg_klv_q       <= cfg_klv_d;
            cfg_step_a_q    <= cfg_step_a_d;
            cfg_step_b_q    <= cfg_step_b_d;
            cfg_timeout_q   <= cfg_timeout_d;
            wd_cnt_q        <= wd_cnt_d;
            mm_start_q      <= mm_start_d;
            mm_clear_done_q <= mm_clear_done_d;
            addr_a_q        <= addr_a_d;
            addr_b_q        <= addr_b_d;
            addr_c_q        <= addr_c_d;
            stride_a_q      <= stride_a_d;
            stride_b_q      <= stride_b_d;
            stride_c_q      <= stride_c_d;
            save_q          <= save_d;
            add_q           <= add_d;
            mask_a_q        <= mask_a_d;
            mask_k_q        <= mask_k_d;
            mask_b_q        <= mask_b_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            tile_idx_q      <= tile_idx_d;
        end
    end

    assign mm_start       = mm_start_q;
    assign mm_clear_done  = mm_clear_done_q;
    assign mm_addr_a      = addr_a_q;
    assign mm_addr_b      = addr_b_q;
    assign mm_addr_c      = addr_c_q;
    assign mm_stride_a    = stride_a_q;
    assign mm_stride_b    = stride_b_q;
    assign mm_stride_c    = stride_c_q;
    assign mm_save_accum  = save_q;
    assign mm_add_accum   = add_q;
    assign mm_mask_a_rows = mask_a_q;
    assign mm_mask_k      = mask_k_q;
    assign mm_mask_b_cols = mask_b_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign tile_idx       = tile_idx_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer with a small latency model of the matmul done flag.
module tb_matmul_tile_sequencer;

    localparam int AW = 11;
    localparam int SW = 8;
    localparam int TL = 8;
    localparam int NT = 4;
    localparam int TW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [NT-1:0]   num_k_tiles = '0;
    logic [3:0]      k_last_valid = '0;
    logic [AW-1:0]   base_a = '0, base_b = '0, base_c = '0, step_a = '0, step_b = '0;
    logic [SW-1:0]   stride_a = '0, stride_b = '0, stride_c = '0;
    logic [TL-1:0]   mask_a_rows = '0, mask_b_cols = '0;
    logic [TW-1:0]   timeout = '0;
    logic            mm_done = 1'b0;
    logic            mm_start, mm_clear_done, mm_save_accum, mm_add_accum;
    logic [AW-1:0]   mm_addr_a, mm_addr_b, mm_addr_c;
    logic [SW-1:0]   mm_stride_a, mm_stride_b, mm_stride_c;
    logic [TL-1:0]   mm_mask_a_rows, mm_mask_k, mm_mask_b_cols;
    logic            busy, done, err;
    logic [NT-1:0]   tile_idx;

    matmul_tile_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .abort          (abort),
        .num_k_tiles    (num_k_tiles),
        .k_last_valid   (k_last_valid),
        .base_a         (base_a),
        .base_b         (base_b),
        .base_c         (base_c),
        .step_a         (step_a),
        .step_b         (step_b),
        .stride_a       (stride_a),
        .stride_b       (stride_b),
        .stride_c       (stride_c),
        .mask_a_rows    (mask_a_rows),
        .mask_b_cols    (mask_b_cols),
        .timeout        (timeout),
        .mm_done        (mm_done),
        .mm_start       (mm_start),
        .mm_clear_done  (mm_clear_done),
        .mm_addr_a      (mm_addr_a),
        .mm_addr_b      (mm_addr_b),
        .mm_addr_c      (mm_addr_c),
        .mm_stride_a    (mm_stride_a),
        .mm_stride_b    (mm_stride_b),
        .mm_stride_c    (mm_stride_c),
        .mm_save_accum  (mm_save_accum),
        .mm_add_accum   (mm_add_accum),
        .mm_mask_a_rows (mm_mask_a_rows),
        .mm_mask_k      (mm_mask_k),
        .mm_mask_b_cols (mm_mask_b_cols),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .tile_idx       (tile_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Matmul model: done rises so that mm_start stays high for exactly lat cycles.
    int lat = 5;
    bit hang = 1'b0;
    int lat_cnt = 0;
    always @(posedge clk) begin
        if (!resetn || mm_clear_done) begin
            mm_done <= 1'b0;
            lat_cnt <= 0;
        end else if (!mm_start) begin
            lat_cnt <= 0;
        end else if (!mm_done && !hang) begin
            if (lat_cnt + 1 == lat - 1) mm_done <= 1'b1;
            lat_cnt <= lat_cnt + 1;
        end
    end

    // Monitor: captures tile launch values at each mm_start rise.
    int rise_cnt = 0, start_hi = 0, clr_hi = 0, done_cnt = 0;
    logic prev_start = 1'b0;
    logic [AW-1:0] cap_a [8];
    logic [AW-1:0] cap_b [8];
    logic [1:0]    cap_f [8];
    logic [TL-1:0] cap_m [8];
    always @(negedge clk) begin
        if (mm_start && !prev_start) begin
            if (rise_cnt < 8) begin
                cap_a[rise_cnt] = mm_addr_a;
                cap_b[rise_cnt] = mm_addr_b;
                cap_f[rise_cnt] = {mm_save_accum, mm_add_accum};
                cap_m[rise_cnt] = mm_mask_k;
            end
            rise_cnt++;
        end
        if (mm_start) start_hi++;
        if (mm_clear_done) clr_hi++;
        if (done) done_cnt++;
        prev_start = mm_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_cnt = 0;
        start_hi = 0;
        clr_hi   = 0;
        done_cnt = 0;
    endtask

    task automatic go(input int n, input int klv, input int ba, input int bb, input int sa,
                      input int sb);
        clear_mon();
        num_k_tiles  = NT'(n);
        k_last_valid = 4'(klv);
        base_a       = AW'(ba);
        base_b       = AW'(bb);
        step_a       = AW'(sa);
        step_b       = AW'(sb);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    logic [1:0] exp_f [3] = '{2'b10, 2'b11, 2'b01};
    logic [95:0] all_out;
    assign all_out = {mm_start, mm_clear_done, mm_addr_a, mm_addr_b, mm_addr_c, mm_stride_a,
                      mm_stride_b, mm_stride_c, mm_save_accum, mm_add_accum, mm_mask_a_rows,
                      mm_mask_k, mm_mask_b_cols, busy, done, err, tile_idx};

    initial begin
        int n;
        // Reset
        tick();
        tick();
        check_eq("rst_outputs", all_out, '0);
        resetn = 1'b1;
        tick();
        check_eq("rst_idle_busy", busy, 1'b0);

        // Single tile, latency 20
        lat = 20;
        base_c = AW'(11'h055);
        mask_a_rows = 8'hFF;
        mask_b_cols = 8'h0F;
        stride_a = 8'd3;
        go(1, 0, 0, 0, 0, 0);
        check_eq("t1_start", mm_start, 1'b1);
        check_eq("t1_flags", {mm_save_accum, mm_add_accum}, 2'b00);
        check_eq("t1_mask_k", mm_mask_k, 8'hFF);
        check_eq("t1_addr_c", mm_addr_c, 11'h055);
        check_eq("t1_pass", {mm_stride_a, mm_mask_b_cols}, {8'd3, 8'h0F});
        wait_done("t1_done_seen");
        check_eq("t1_busy_with_done", busy, 1'b1);
        tick();
        check_eq("t1_done_drop", {done, busy}, 2'b00);
        check_eq("t1_start_cycles", start_hi, 20);
        check_eq("t1_clear_cycles", clr_hi, 2);
        check_eq("t1_done_cnt", done_cnt, 1);

        // Three tiles
        lat = 5;
        go(3, 0, 0, 'h100, 8, 64);
        wait_idle("t2_idle");
        check_eq("t2_starts", rise_cnt, 3);
        check_eq("t2_dones", done_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t2_addr_a%0d", i), cap_a[i], 11'(8 * i));
            check_eq($sformatf("t2_addr_b%0d", i), cap_b[i], 11'('h100 + 64 * i));
            check_eq($sformatf("t2_flags%0d", i), cap_f[i], exp_f[i]);
        end

        // Ragged last tile
        go(2, 3, 0, 0, 0, 0);
        wait_idle("t3_idle");
        check_eq("t3_mask0", cap_m[0], 8'hFF);
        check_eq("t3_mask1", cap_m[1], 8'h07);

        // Watchdog
        hang = 1'b1;
        timeout = 16'd10;
        go(2, 0, 0, 0, 0, 0);
        wait_idle("t4_idle");
        check_eq("t4_start_cycles", start_hi, 10);
        check_eq("t4_err", err, 1'b1);
        check_eq("t4_no_done", done_cnt, 0);
        hang = 1'b0;
        timeout = '0;
        go(1, 0, 0, 0, 0, 0);
        check_eq("t4_err_cleared", err, 1'b0);
        wait_idle("t4b_idle");

        // Zero tiles
        go(0, 0, 0, 0, 0, 0);
        check_eq("t5_done", {done, mm_start}, 2'b10);
        tick();
        check_eq("t5_after", {done, busy}, 2'b00);
        check_eq("t5_no_start", rise_cnt, 0);

        // Abort in RUN of tile 1
        go(3, 0, 0, 0, 8, 8);
        n = 0;
        while (!(tile_idx == NT'(1) && mm_start) && n < 300) begin
            tick();
            n++;
        end
        check_eq("t6_reach_tile1", (tile_idx == NT'(1)) && mm_start, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t6_abort", {mm_start, mm_clear_done, busy}, 3'b000);
        check_eq("t6_tile_idx", tile_idx, 4'd1);
        check_eq("t6_no_done", done_cnt, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_eq("t6_abort_beats_start", busy, 1'b0);

        // Reset during CLEAR
        go(2, 0, 0, 0, 0, 0);
        n = 0;
        while (!mm_clear_done && n < 300) begin
            tick();
            n++;
        end
        check_eq("t7_reach_clear", mm_clear_done, 1'b1);
        resetn = 1'b0;
        tick();
        check_eq("t7_rst_outputs", all_out, '0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check_eq("t7_no_done", done_cnt, 0);

        // start held high while running; config changes ignored after acceptance
        clear_mon();
        num_k_tiles = 4'd2;
        k_last_valid = '0;
        base_a = 11'h020;
        step_a = 11'h004;
        start = 1'b1;
        tick();
        base_a = 11'h300;
        step_a = 11'h010;
        wait_done("t8_done_seen");
        start = 1'b0;
        tick();
        check_eq("t8_idle", busy, 1'b0);
        check_eq("t8_starts", rise_cnt, 2);
        check_eq("t8_dones", done_cnt, 1);
        check_eq("t8_latched_addr", cap_a[1], 11'h024);

        // Address wrap
        go(2, 0, 'h7FC, 0, 8, 0);
        wait_idle("t9_idle");
        check_eq("t9_wrap", cap_a[1], 11'h004);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/matmul_tile_sequencer.md
# matmul_tile_sequencer

Parametrised run sequencer placed in front of `matrix_multiplication`. It drives the matmul's start / clear_done handshake over a K-dimension sequence of tiles and steps the A/B RAM base addresses per tile. It also drives the accumulator flags so partial products chain into a single C tile, and masks the ragged last tile. It replaces hand-sequenced start/clear_done stimulus with a reusable synthesizable controller and adds a done-timeout watchdog and an abort path.

## Interface
- AWIDTH, 11, RAM address width (matches matmul address ports)
- SWIDTH, 8, address stride width
- TILE, 8, systolic array dimension (mask width)
- NTW, 4, width of tile count
- TOW, 16, width of timeout counter
- clk  input  1  sole clock
- resetn  input  1  reset, synchronous, active-low
- start  input  1  level; sampled only in IDLE
- abort  input  1  return to IDLE next cycle from any state
- num_k_tiles  input  NTW  number of K tiles (0 allowed)
- k_last_valid  input  log2(TILE)+1  valid K columns in last tile, 1..TILE; 0 means TILE
- base_a, base_b, base_c  input  AWIDTH each  first-tile base addresses
- step_a, step_b  input  AWIDTH each  per-tile address increment
- stride_a, stride_b, stride_c  input  SWIDTH each  passed through to matmul
- mask_a_rows, mask_b_cols  input  TILE each  passed through
- timeout  input  TOW  max cycles in RUN; 0 disables watchdog
- mm_done  input  1  matmul done_mat_mul
- mm_start, mm_clear_done  output  1 each  matmul start_reg / clear_done_reg
- mm_addr_a, mm_addr_b, mm_addr_c  output  AWIDTH each
- mm_stride_a, mm_stride_b, mm_stride_c  output  SWIDTH each
- mm_save_accum, mm_add_accum  output  1 each  save_output_to_accum / add_accum_to_output
- mm_mask_a_rows, mm_mask_k, mm_mask_b_cols  output  TILE each
- busy  output  1  high in any state but IDLE
- done  output  1  one-cycle pulse on sequence completion
- err  output  1  sticky timeout flag, cleared on accepted start
- tile_idx  output  NTW  current K tile index

## Operation
- FSM states: IDLE, RUN, CLEAR, FIN, ERR.
- IDLE:
  - On start=1, latch all config inputs into registers; input changes after acceptance are ignored.
  - If num_k_tiles=0 -> FIN. Otherwise tile_idx=0, addr_a=base_a, addr_b=base_b -> RUN.
- RUN:
  - mm_start=1.
  - On mm_done=1 -> CLEAR.
  - If timeout!=0 and the RUN cycle count reaches timeout -> ERR.
- CLEAR:
  - mm_start=0, mm_clear_done=1.
  - When mm_done=0: if tile_idx = num_k_tiles-1 -> FIN. Otherwise tile_idx+1, addr_a+=step_a, addr_b+=step_b (modulo 2^AWIDTH) -> RUN.
- FIN: done=1 for one cycle -> IDLE.
- ERR: err=1, mm_start=0, mm_clear_done=1 until mm_done=0 -> IDLE. No done pulse.
- abort=1, any state: -> IDLE next edge. mm_start and mm_clear_done drop; err and tile_idx are held. abort has priority over start.
- start while busy is ignored.
- mm_addr_c = base_c for every tile.
- Accumulator flags, with n = num_k_tiles and k = tile_idx:
  - n=1: save=0, add=0.
  - k=0 with n>1: save=1, add=0.
  - 0<k<n-1: save=1, add=1.
  - k=n-1 with n>1: save=0, add=1.
- mm_mask_k: all ones, except on the last tile = (1<<k_last_valid)-1 (all ones when k_last_valid is 0 or TILE).
- Stride and row/col masks are registered copies of the latched config.
- Outputs are registered.

## Timing
- Reset (resetn=0 at a clk edge), all outputs reset to 0 and state goes to IDLE.
  - This covers mm_start, mm_clear_done, addresses, flags, masks, busy, done, err and tile_idx.
  - Reset mid-run abandons the sequence with no done pulse.
- start sampled at edge t -> mm_start=1 with valid addresses, flags and masks from t+1.
- Addresses, flags and masks change only on the CLEAR->RUN edge. They are stable for the whole RUN/CLEAR window of each tile.
- mm_done high at edge t in RUN -> mm_start=0, mm_clear_done=1 from t+1.
- mm_done low at edge t in CLEAR -> next tile's mm_start=1 from t+1. The last tile instead raises done for t+1 only.
- Per tile, minimum turnaround is 2 cycles beyond the matmul's own latency.
- The watchdog counter resets on entry to RUN. With timeout=T, ERR is entered on the T-th consecutive RUN cycle without mm_done.

## Test plan
- Single tile (num_k_tiles=1, bases 0, mm_done model 20 cycles):
  - mm_start high 20 cycles, then clear_done handshake.
  - save=0, add=0, mm_mask_k=8'hFF.
  - done pulses once; busy falls the same cycle done drops.
- Three tiles, base_a=0, base_b=0x100, step_a=8, step_b=64:
  - addr_a 0, 8, 16 and addr_b 0x100, 0x140, 0x180.
  - Flags (save,add) = (1,0), (1,1), (0,1).
  - Exactly 3 start pulses, 1 done.
- Ragged K, num_k_tiles=2, k_last_valid=3: mm_mask_k = 8'hFF on tile 0 and 8'h07 on tile 1.
- Timeout=10 with mm_done stuck low:
  - ERR on the 10th RUN cycle, err=1, no done.
  - The next start clears err.
- num_k_tiles=0: done pulses the cycle after start, and mm_start never rises.
- Abort in RUN of tile 1 of 3: next cycle IDLE, mm_start=0, busy=0, tile_idx=1.
- Reset asserted during CLEAR: all outputs 0, no done pulse.
- start held high during RUN is ignored.
- Address wrap: base_a=0x7FC, step_a=8 -> tile 1 addr_a=0x004.
